// File: rtl/fx_pkg.sv
// Shared fixed-point arithmetic definitions: frame FSM states and default
// widths with the saturation bounds that follow from them.
package fx_pkg;

   typedef enum logic [1:0] {IDLE, ACCUM, HOLD} fx_state_t;

   localparam int FX_DATA_WIDTH  = 32;
   localparam int FX_ACC_WIDTH   = 40;
   localparam int FX_COUNT_WIDTH = 8;

   localparam logic [FX_DATA_WIDTH-1:0] FX_DATA_MAX = {1'b0, {(FX_DATA_WIDTH-1){1'b1}}};
   localparam logic [FX_DATA_WIDTH-1:0] FX_DATA_MIN = {1'b1, {(FX_DATA_WIDTH-1){1'b0}}};
   localparam logic [FX_ACC_WIDTH-1:0]  FX_ACC_MAX  = {1'b0, {(FX_ACC_WIDTH-1){1'b1}}};
   localparam logic [FX_ACC_WIDTH-1:0]  FX_ACC_MIN  = {1'b1, {(FX_ACC_WIDTH-1){1'b0}}};

endpackage

// File: rtl/fx_sat.sv
// Combinational signed narrowing IN_WIDTH -> OUT_WIDTH; clamps to the
// representable range and flags when it had to.
module fx_sat #(
   parameter int IN_WIDTH  = 40,
   parameter int OUT_WIDTH = 32
) (
   input  logic [IN_WIDTH-1:0]  din,
   output logic [OUT_WIDTH-1:0] dout,
   output logic                 clamp
);

   // Value fits iff all bits from the output sign bit upward agree.
   logic [IN_WIDTH-OUT_WIDTH:0] hi;

   always_comb begin
      hi    = din[IN_WIDTH-1:OUT_WIDTH-1];
      clamp = !((&hi) || !(|hi));
      if (!clamp)
         dout = din[OUT_WIDTH-1:0];
      else if (din[IN_WIDTH-1])
         dout = {1'b1, {(OUT_WIDTH-1){1'b0}}};
      else
         dout = {1'b0, {(OUT_WIDTH-1){1'b1}}};
   end

endmodule

// File: rtl/fx_acc_add.sv
// Streaming saturating accumulator: sums a frame of signed samples and
// presents one narrowed result with a sticky overflow flag.
module fx_acc_add
   import fx_pkg::*;
#(
   parameter int DATA_WIDTH  = FX_DATA_WIDTH,
   parameter int ACC_WIDTH   = FX_ACC_WIDTH,
   parameter int COUNT_WIDTH = FX_COUNT_WIDTH
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   i_clear,
   input  logic [COUNT_WIDTH-1:0] i_len,
   input  logic                   i_valid,
   output logic                   o_ready,
   input  logic [DATA_WIDTH-1:0]  i_data,
   output logic                   o_valid,
   input  logic                   i_ready,
   output logic [DATA_WIDTH-1:0]  o_result,
   output logic                   o_overflow,
   output logic [COUNT_WIDTH-1:0] o_count
);

   localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
   localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

   fx_state_t              state, state_nxt;
   logic [ACC_WIDTH-1:0]   acc, base, d_ext, acc_nxt;
   logic [ACC_WIDTH:0]     sum;
   logic [COUNT_WIDTH-1:0] count, len, len_eff, cnt_nxt;
   logic [DATA_WIDTH-1:0]  sat_res;
   logic                   flag, flag_nxt, acc_ovf, clamp, last, in_xfer, out_xfer;

   assign o_ready    = (state != HOLD);
   assign o_valid    = (state == HOLD);
   assign o_count    = count;
   assign o_overflow = flag;
   assign in_xfer    = i_valid && o_ready;
   assign out_xfer   = o_valid && i_ready;

   // First sample of a frame loads rather than adds, so base is zero in IDLE.
   always_comb begin
      base     = (state == IDLE) ? '0 : acc;
      d_ext    = {{(ACC_WIDTH-DATA_WIDTH){i_data[DATA_WIDTH-1]}}, i_data};
      sum      = {base[ACC_WIDTH-1], base} + {d_ext[ACC_WIDTH-1], d_ext};
      acc_ovf  = sum[ACC_WIDTH] ^ sum[ACC_WIDTH-1];
      acc_nxt  = acc_ovf ? (sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX) : sum[ACC_WIDTH-1:0];
      flag_nxt = ((state == IDLE) ? 1'b0 : flag) | acc_ovf;
      len_eff  = (state != IDLE) ? len :
                 (i_len == '0)   ? COUNT_WIDTH'(1) : i_len;
      cnt_nxt  = (state == IDLE) ? COUNT_WIDTH'(1) : count + COUNT_WIDTH'(1);
      last     = (cnt_nxt == len_eff);
   end

   fx_sat #(.IN_WIDTH(ACC_WIDTH), .OUT_WIDTH(DATA_WIDTH)) u_sat (
      .din   (acc_nxt),
      .dout  (sat_res),
      .clamp (clamp)
   );

   always_comb begin
      state_nxt = state;
      if (i_clear)
         state_nxt = IDLE;
      else
         case (state)
            IDLE:    if (in_xfer) state_nxt = last ? HOLD : ACCUM;
            ACCUM:   if (in_xfer && last) state_nxt = HOLD;
            HOLD:    if (out_xfer) state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         acc      <= '0;
         count    <= '0;
         len      <= '0;
         flag     <= 1'b0;
         o_result <= '0;
      end else begin
         state <= state_nxt;
         if (i_clear) begin
            acc   <= '0;
            count <= '0;
            flag  <= 1'b0;
         end else if (in_xfer) begin
            acc   <= acc_nxt;
            count <= cnt_nxt;
            flag  <= flag_nxt | (last & clamp);
            if (state == IDLE) len <= len_eff;
            if (last) o_result <= sat_res;
         end else if (out_xfer) begin
            acc   <= '0;
            count <= '0;
            flag  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_fx_acc_add.sv
// Scenario bench for fx_acc_add: a longint model feeds an expected-result
// queue that is drained as the DUT presents each frame result.
module tb_fx_acc_add;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        i_clear = 1'b0;
   logic [7:0]  i_len = 8'd1;
   logic        i_valid = 1'b0;
   logic        o_ready;
   logic [31:0] i_data = '0;
   logic        o_valid;
   logic        i_ready = 1'b1;
   logic [31:0] o_result;
   logic        o_overflow;
   logic [7:0]  o_count;

   typedef struct packed {
      logic [31:0] res;
      logic        ovf;
   } exp_t;

   exp_t               exp_q[$];
   logic signed [31:0] stim_q[$];
   int                 n_total = 0;
   int                 n_pass  = 0;

   fx_acc_add #(.DATA_WIDTH(32), .ACC_WIDTH(40), .COUNT_WIDTH(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_clear    (i_clear),
      .i_len      (i_len),
      .i_valid    (i_valid),
      .o_ready    (o_ready),
      .i_data     (i_data),
      .o_valid    (o_valid),
      .i_ready    (i_ready),
      .o_result   (o_result),
      .o_overflow (o_overflow),
      .o_count    (o_count)
   );

   always #5 clk = ~clk;

   // Inputs change 1 time unit after the rising edge; outputs are read then too.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic put(input logic [31:0] d);
      int k = 0;
      while (!o_ready && k < 50) begin step(); k++; end
      if (!o_ready) begin
         n_total++;
         $display("FAIL put_timeout: o_ready=%b required 1", o_ready);
      end
      i_valid = 1'b1;
      i_data  = d;
      step();
      i_valid = 1'b0;
   endtask

   // Drives stim_q as one frame and pushes the model's expected result.
   task automatic send_frame(input logic [7:0] len);
      longint acc = 0;
      logic   ov  = 1'b0;
      exp_t   e;
      i_len = len;
      foreach (stim_q[i]) begin
         acc += longint'(stim_q[i]);
         if (acc > 64'sd549755813887)       begin acc = 64'sd549755813887;  ov = 1'b1; end
         else if (acc < -64'sd549755813888) begin acc = -64'sd549755813888; ov = 1'b1; end
      end
      if (acc > 64'sd2147483647)       begin e.res = 32'h7FFF_FFFF; ov = 1'b1; end
      else if (acc < -64'sd2147483648) begin e.res = 32'h8000_0000; ov = 1'b1; end
      else e.res = acc[31:0];
      e.ovf = ov;
      exp_q.push_back(e);
      foreach (stim_q[i]) put(stim_q[i]);
      stim_q.delete();
   endtask

   task automatic wait_valid(output bit ok);
      int k = 0;
      while (!o_valid && k < 50) begin step(); k++; end
      ok = o_valid;
   endtask

   task automatic pop_exp(output exp_t e);
      if (exp_q.size() == 0) e = '{res: 32'hDEAD_BEEF, ovf: 1'bx};
      else e = exp_q.pop_front();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #3;
      n_total++; if (o_ready !== 1'b1)    $display("FAIL reset_ready: got %b want 1", o_ready);    else n_pass++;
      n_total++; if (o_valid !== 1'b0)    $display("FAIL reset_valid: got %b want 0", o_valid);    else n_pass++;
      n_total++; if (o_result !== 32'h0)  $display("FAIL reset_result: got %h want 0", o_result);  else n_pass++;
      n_total++; if (o_overflow !== 1'b0) $display("FAIL reset_ovf: got %b want 0", o_overflow);   else n_pass++;
      n_total++; if (o_count !== 8'd0)    $display("FAIL reset_count: got %0d want 0", o_count);   else n_pass++;
      step(); step();
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_basic();
      exp_t e;
      i_ready = 1'b1;
      i_len   = 8'd4;
      exp_q.push_back('{res: 32'd15, ovf: 1'b0});
      put(32'd10);
      put(-32'sd3);
      n_total++; if (o_count !== 8'd2) $display("FAIL basic_mid_count: got %0d want 2", o_count); else n_pass++;
      put(32'd7);
      put(32'd1);
      pop_exp(e);
      n_total++; if (o_valid !== 1'b1)    $display("FAIL basic_valid: got %b want 1", o_valid);       else n_pass++;
      n_total++; if (o_result !== e.res)  $display("FAIL basic_result: got %h want %h", o_result, e.res); else n_pass++;
      n_total++; if (o_overflow !== e.ovf) $display("FAIL basic_ovf: got %b want %b", o_overflow, e.ovf); else n_pass++;
      n_total++; if (o_count !== 8'd4)    $display("FAIL basic_count: got %0d want 4", o_count);      else n_pass++;
      n_total++; if (o_ready !== 1'b0)    $display("FAIL basic_ready_low: got %b want 0", o_ready);   else n_pass++;
      step();
      n_total++; if (o_ready !== 1'b1 || o_valid !== 1'b0)
         $display("FAIL basic_after_xfer: ready=%b valid=%b want 1/0", o_ready, o_valid); else n_pass++;
      n_total++; if (o_count !== 8'd0) $display("FAIL basic_count_clr: got %0d want 0", o_count); else n_pass++;
   endtask

   task automatic test_saturation();
      exp_t e;
      bit   ok;
      stim_q = '{32'sh7FFF_FFFF, 32'sh7FFF_FFFF};
      send_frame(8'd2);
      wait_valid(ok); pop_exp(e);
      n_total++; if (!ok || o_result !== e.res || o_overflow !== e.ovf)
         $display("FAIL sat_pos: got %h/%b want %h/%b", o_result, o_overflow, e.res, e.ovf); else n_pass++;
      step();
      stim_q = '{32'sh8000_0000, 32'sh8000_0000};
      send_frame(8'd2);
      wait_valid(ok); pop_exp(e);
      n_total++; if (!ok || o_result !== e.res || o_overflow !== e.ovf)
         $display("FAIL sat_neg: got %h/%b want %h/%b", o_result, o_overflow, e.res, e.ovf); else n_pass++;
      step();
   endtask

   task automatic test_len_zero();
      exp_t e;
      stim_q = '{-32'sd5};
      send_frame(8'd0);
      pop_exp(e);
      n_total++; if (o_valid !== 1'b1 || o_result !== e.res || o_overflow !== e.ovf)
         $display("FAIL len_zero: valid=%b got %h/%b want %h/%b", o_valid, o_result, o_overflow, e.res, e.ovf); else n_pass++;
      step();
   endtask

   task automatic test_back_to_back();
      exp_t e;
      bit   bad = 1'b0;
      i_ready = 1'b0;
      stim_q = '{32'sd3, 32'sd4};
      send_frame(8'd2);
      pop_exp(e);
      i_len   = 8'd1;
      i_valid = 1'b1;
      i_data  = 32'd100;
      for (int c = 0; c < 5; c++) begin
         step();
         if (o_ready !== 1'b0 || o_valid !== 1'b1 || o_result !== e.res || o_count !== 8'd2) bad = 1'b1;
      end
      n_total++; if (bad) $display("FAIL bp_hold: ready=%b valid=%b result=%h count=%0d want 0/1/%h/2",
                                   o_ready, o_valid, o_result, o_count, e.res); else n_pass++;
      i_ready = 1'b1;
      exp_q.push_back('{res: 32'd100, ovf: 1'b0});
      step();
      n_total++; if (o_ready !== 1'b1 || o_valid !== 1'b0)
         $display("FAIL bp_xfer: ready=%b valid=%b want 1/0", o_ready, o_valid); else n_pass++;
      step();
      i_valid = 1'b0;
      pop_exp(e);
      n_total++; if (o_valid !== 1'b1 || o_result !== e.res)
         $display("FAIL bp_next_frame: valid=%b got %h want 1/%h", o_valid, o_result, e.res); else n_pass++;
      step();
   endtask

   task automatic test_clear();
      exp_t e;
      bit   seen = 1'b0;
      bit   ok;
      i_len = 8'd4;
      put(32'd1);
      put(32'd2);
      i_valid = 1'b1;
      i_data  = 32'd50;
      i_clear = 1'b1;
      step();
      i_clear = 1'b0;
      i_valid = 1'b0;
      n_total++; if (o_count !== 8'd0 || o_ready !== 1'b1)
         $display("FAIL clear_state: count=%0d ready=%b want 0/1", o_count, o_ready); else n_pass++;
      for (int c = 0; c < 4; c++) begin
         if (o_valid !== 1'b0) seen = 1'b1;
         step();
      end
      n_total++; if (seen) $display("FAIL clear_no_valid: o_valid seen 1 want 0"); else n_pass++;
      stim_q = '{32'sd9};
      send_frame(8'd1);
      wait_valid(ok); pop_exp(e);
      n_total++; if (!ok || o_result !== e.res || o_overflow !== e.ovf)
         $display("FAIL clear_refill: got %h/%b want %h/%b", o_result, o_overflow, e.res, e.ovf); else n_pass++;
      step();
   endtask

   task automatic test_reset_mid();
      exp_t e;
      bit   ok;
      i_len = 8'd3;
      put(32'd5);
      put(32'd6);
      rst_n = 1'b0;
      #1;
      n_total++; if (o_count !== 8'd0 || o_ready !== 1'b1 || o_valid !== 1'b0)
         $display("FAIL rst_accum: count=%0d ready=%b valid=%b want 0/1/0", o_count, o_ready, o_valid); else n_pass++;
      step();
      rst_n = 1'b1;
      step();
      i_ready = 1'b0;
      stim_q = '{32'sd20, 32'sd22};
      send_frame(8'd2);
      wait_valid(ok); pop_exp(e);
      n_total++; if (!ok || o_result !== e.res)
         $display("FAIL rst_hold_pre: got %h want %h", o_result, e.res); else n_pass++;
      rst_n = 1'b0;
      #1;
      n_total++; if (o_valid !== 1'b0 || o_result !== 32'h0 || o_overflow !== 1'b0 || o_ready !== 1'b1)
         $display("FAIL rst_hold: valid=%b result=%h ovf=%b ready=%b want 0/0/0/1",
                  o_valid, o_result, o_overflow, o_ready); else n_pass++;
      step();
      rst_n   = 1'b1;
      i_ready = 1'b1;
      step();
      stim_q = '{32'sd5, 32'sd6};
      send_frame(8'd2);
      wait_valid(ok); pop_exp(e);
      n_total++; if (!ok || o_result !== e.res || o_overflow !== e.ovf)
         $display("FAIL rst_fresh: got %h/%b want %h/%b", o_result, o_overflow, e.res, e.ovf); else n_pass++;
      step();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_saturation();
      test_len_zero();
      test_back_to_back();
      test_clear();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
